// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq: operands and select in, registered result and flags out.
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             valid_in;
  logic             ready_out;
  logic [2:0]       unit_sel_in;
  logic             op_sel_in;
  logic [WIDTH-1:0] acc_in;
  logic [WIDTH-1:0] src_in;
  logic             valid_out;
  logic [WIDTH-1:0] res_out;
  logic             zero_out;
  logic             neg_out;
  logic             carry_out;
  logic             ovf_out;

  modport master (
    output valid_in, unit_sel_in, op_sel_in, acc_in, src_in,
    input  ready_out, valid_out, res_out, zero_out, neg_out, carry_out, ovf_out
  );

  modport slave (
    input  valid_in, unit_sel_in, op_sel_in, acc_in, src_in,
    output ready_out, valid_out, res_out, zero_out, neg_out, carry_out, ovf_out
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with flags: 1-cycle latency for all units except multiply (WIDTH cycles, shift-add).
// ready_out drops for the whole multiply; requests seen while not ready are dropped, not queued.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic     clk_in,
  input logic     rst_in,
  alu_seq_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = $clog2(WIDTH) + 1;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             r_state;
  logic               r_ready;
  logic               r_valid;
  logic [WIDTH-1:0]   r_res;
  logic               r_zero;
  logic               r_neg;
  logic               r_carry;
  logic               r_ovf;
  logic               r_mul_hi;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_pp;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_ovf;
  logic [WIDTH:0]     w_pp_sum;
  logic [2*WIDTH-1:0] w_pp_nxt;
  logic [WIDTH-1:0]   w_mul_res;
  logic               w_mul_carry;

  assign w_accept = bus.valid_in & r_ready;

  always_comb begin
    w_addend = bus.op_sel_in ? ~bus.src_in : bus.src_in;
    w_sum    = {1'b0, bus.acc_in} + {1'b0, w_addend} + {{WIDTH{1'b0}}, bus.op_sel_in};
    w_shamt  = bus.src_in[SHAMT_W-1:0];
    // Extra bit on the shifted-out side captures the last bit lost; it stays 0 for a zero shift.
    w_shl    = {1'b0, bus.acc_in} << w_shamt;
    w_shr    = {bus.acc_in, 1'b0} >> w_shamt;
    w_res    = '0;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    case (bus.unit_sel_in)
      3'b000: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (bus.acc_in[WIDTH-1] == w_addend[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != bus.acc_in[WIDTH-1]);
      end
      3'b001: w_res = bus.op_sel_in ? ~(bus.acc_in & bus.src_in) : (bus.acc_in & bus.src_in);
      3'b010: begin
        w_res   = bus.op_sel_in ? w_shr[WIDTH:1] : w_shl[WIDTH-1:0];
        w_carry = bus.op_sel_in ? w_shr[0] : w_shl[WIDTH];
      end
      3'b011: w_res = bus.src_in;
      3'b100: w_res = bus.acc_in | bus.src_in;
      3'b101: w_res = bus.acc_in ^ bus.src_in;
      3'b111: w_res = bus.acc_in;
      default: w_res = '0;
    endcase
  end

  // Upper half accumulates, lower half holds the multiplier and shifts out one bit per step.
  always_comb begin
    w_pp_sum    = {1'b0, r_pp[2*WIDTH-1:WIDTH]} + (r_pp[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    w_pp_nxt    = {w_pp_sum, r_pp[WIDTH-1:1]};
    w_mul_res   = r_mul_hi ? w_pp_nxt[2*WIDTH-1:WIDTH] : w_pp_nxt[WIDTH-1:0];
    w_mul_carry = ~r_mul_hi & (|w_pp_nxt[2*WIDTH-1:WIDTH]);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_res    <= '0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_mul_hi <= 1'b0;
      r_mcand  <= '0;
      r_pp     <= '0;
      r_cnt    <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (bus.unit_sel_in == 3'b110) begin
              r_mcand  <= bus.acc_in;
              r_pp     <= {{WIDTH{1'b0}}, bus.src_in};
              r_mul_hi <= bus.op_sel_in;
              r_cnt    <= CNT_W'(WIDTH);
              r_ready  <= 1'b0;
              r_state  <= S_MUL;
            end else begin
              r_res   <= w_res;
              r_zero  <= ~|w_res;
              r_neg   <= w_res[WIDTH-1];
              r_carry <= w_carry;
              r_ovf   <= w_ovf;
              r_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_pp  <= w_pp_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_res   <= w_mul_res;
            r_zero  <= ~|w_mul_res;
            r_neg   <= w_mul_res[WIDTH-1];
            r_carry <= w_mul_carry;
            r_ovf   <= 1'b0;
            r_valid <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready_out = r_ready;
  assign bus.valid_out = r_valid;
  assign bus.res_out   = r_res;
  assign bus.zero_out  = r_zero;
  assign bus.neg_out   = r_neg;
  assign bus.carry_out = r_carry;
  assign bus.ovf_out   = r_ovf;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): each scenario task drives vectors and checks hand-computed results.
module tb_alu_seq;
  logic clk_in;
  logic rst_in;
  int   n_checks;
  int   n_fail;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic issue(input logic [2:0] unit, input logic op, input logic [7:0] a, input logic [7:0] b);
    bus.unit_sel_in = unit;
    bus.op_sel_in   = op;
    bus.acc_in      = a;
    bus.src_in      = b;
    bus.valid_in    = 1'b1;
    @(posedge clk_in); #1;
    bus.valid_in    = 1'b0;
  endtask

  // Starts a multiply and waits for ready_out to come back; hold keeps a new add request asserted meanwhile.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic op, input logic hold,
                         output int low, output logic early_vld, output logic timeout);
    bus.unit_sel_in = 3'b110;
    bus.op_sel_in   = op;
    bus.acc_in      = a;
    bus.src_in      = b;
    bus.valid_in    = 1'b1;
    @(posedge clk_in); #1;
    if (hold) begin
      bus.unit_sel_in = 3'b000;
      bus.op_sel_in   = 1'b0;
      bus.acc_in      = 8'h10;
      bus.src_in      = 8'h20;
    end else begin
      bus.valid_in = 1'b0;
    end
    low = 0; early_vld = 1'b0; timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.ready_out) begin
        timeout = 1'b0;
        break;
      end
      low++;
      if (bus.valid_out) early_vld = 1'b1;
      @(posedge clk_in); #1;
    end
  endtask

  task automatic test_reset;
    n_checks++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready_out); end
    n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.valid_out); end
    n_checks++; if (bus.res_out !== 8'h00) begin n_fail++; $display("FAIL reset_res: got %h want 00", bus.res_out); end
    n_checks++;
    if ({bus.zero_out, bus.neg_out, bus.carry_out, bus.ovf_out} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {bus.zero_out, bus.neg_out, bus.carry_out, bus.ovf_out});
    end
  endtask

  task automatic test_add_overflow;
    issue(3'b000, 1'b0, 8'h7F, 8'h01);
    n_checks++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", bus.valid_out); end
    n_checks++; if (bus.res_out !== 8'h80) begin n_fail++; $display("FAIL add_res: got %h want 80", bus.res_out); end
    n_checks++;
    if ({bus.zero_out, bus.neg_out, bus.carry_out, bus.ovf_out} !== 4'b0101) begin
      n_fail++; $display("FAIL add_flags zncv: got %b want 0101", {bus.zero_out, bus.neg_out, bus.carry_out, bus.ovf_out});
    end
    @(posedge clk_in); #1;
    n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL add_pulse: got %b want 0", bus.valid_out); end
    n_checks++; if (bus.res_out !== 8'h80) begin n_fail++; $display("FAIL add_hold: got %h want 80", bus.res_out); end
  endtask

  task automatic test_sub_zero;
    issue(3'b000, 1'b1, 8'h05, 8'h05);
    n_checks++; if (bus.res_out !== 8'h00) begin n_fail++; $display("FAIL sub_res: got %h want 00", bus.res_out); end
    n_checks++;
    if ({bus.zero_out, bus.neg_out, bus.carry_out, bus.ovf_out} !== 4'b1010) begin
      n_fail++; $display("FAIL sub_flags zncv: got %b want 1010", {bus.zero_out, bus.neg_out, bus.carry_out, bus.ovf_out});
    end
  endtask

  task automatic test_shifts;
    bus.unit_sel_in = 3'b010; bus.op_sel_in = 1'b1; bus.acc_in = 8'h81; bus.src_in = 8'h0B;
    bus.valid_in = 1'b1;
    @(posedge clk_in); #1;
    n_checks++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL shr_valid: got %b want 1", bus.valid_out); end
    n_checks++; if (bus.res_out !== 8'h10) begin n_fail++; $display("FAIL shr_res: got %h want 10", bus.res_out); end
    n_checks++; if (bus.carry_out !== 1'b0) begin n_fail++; $display("FAIL shr_carry: got %b want 0", bus.carry_out); end
    bus.op_sel_in = 1'b0; bus.src_in = 8'h01;
    @(posedge clk_in); #1;
    bus.valid_in = 1'b0;
    n_checks++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL shl_valid: got %b want 1", bus.valid_out); end
    n_checks++; if (bus.res_out !== 8'h02) begin n_fail++; $display("FAIL shl_res: got %h want 02", bus.res_out); end
    n_checks++; if (bus.carry_out !== 1'b1) begin n_fail++; $display("FAIL shl_carry: got %b want 1", bus.carry_out); end
    issue(3'b010, 1'b0, 8'h81, 8'h08);
    n_checks++;
    if ({bus.res_out, bus.carry_out} !== {8'h81, 1'b0}) begin
      n_fail++; $display("FAIL shl0_res_carry: got %h/%b want 81/0", bus.res_out, bus.carry_out);
    end
  endtask

  task automatic test_logic;
    logic [2:0] units [6];
    logic       ops   [6];
    logic [7:0] exps  [6];
    units = '{3'b001, 3'b001, 3'b011, 3'b100, 3'b101, 3'b111};
    ops   = '{1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b1};
    exps  = '{8'h30,  8'hCF,  8'h3C,  8'hFC,  8'hCC,  8'hF0};
    for (int i = 0; i < 6; i++) begin
      issue(units[i], ops[i], 8'hF0, 8'h3C);
      n_checks++;
      if ({bus.res_out, bus.neg_out, bus.carry_out, bus.ovf_out} !== {exps[i], exps[i][7], 2'b00}) begin
        n_fail++;
        $display("FAIL logic_u%0d: got %h n%b c%b v%b want %h n%b c0 v0", units[i], bus.res_out,
                 bus.neg_out, bus.carry_out, bus.ovf_out, exps[i], exps[i][7]);
      end
    end
  endtask

  task automatic test_multiply;
    int   low;
    logic early, tmo;
    run_mul(8'h0F, 8'h11, 1'b0, 1'b0, low, early, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL mul1_timeout: ready_out never returned"); end
    n_checks++; if (low != 8) begin n_fail++; $display("FAIL mul1_ready_low: got %0d cycles want 8", low); end
    n_checks++; if (early) begin n_fail++; $display("FAIL mul1_early_valid: got valid during MUL want none"); end
    n_checks++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL mul1_valid: got %b want 1", bus.valid_out); end
    n_checks++;
    if ({bus.res_out, bus.carry_out, bus.ovf_out} !== {8'hFF, 2'b00}) begin
      n_fail++; $display("FAIL mul1_res: got %h c%b v%b want ff c0 v0", bus.res_out, bus.carry_out, bus.ovf_out);
    end
    run_mul(8'hFF, 8'hFF, 1'b0, 1'b0, low, early, tmo);
    n_checks++;
    if (tmo || {bus.res_out, bus.carry_out, bus.neg_out} !== {8'h01, 2'b10}) begin
      n_fail++; $display("FAIL mul2_lo: got %h c%b n%b tmo%b want 01 c1 n0", bus.res_out, bus.carry_out, bus.neg_out, tmo);
    end
    run_mul(8'hFF, 8'hFF, 1'b1, 1'b0, low, early, tmo);
    n_checks++;
    if (tmo || {bus.res_out, bus.carry_out, bus.neg_out, bus.zero_out} !== {8'hFE, 3'b010}) begin
      n_fail++; $display("FAIL mul3_hi: got %h c%b n%b z%b want fe c0 n1 z0", bus.res_out, bus.carry_out,
                         bus.neg_out, bus.zero_out);
    end
  endtask

  task automatic test_stall;
    int   low;
    logic early, tmo;
    run_mul(8'h0F, 8'h11, 1'b0, 1'b1, low, early, tmo);
    n_checks++; if (tmo || low != 8) begin n_fail++; $display("FAIL stall_ready_low: got %0d tmo%b want 8", low, tmo); end
    n_checks++; if (early) begin n_fail++; $display("FAIL stall_early_valid: got valid during MUL want none"); end
    n_checks++;
    if ({bus.valid_out, bus.res_out} !== {1'b1, 8'hFF}) begin
      n_fail++; $display("FAIL stall_mul_res: got v%b %h want v1 ff", bus.valid_out, bus.res_out);
    end
    @(posedge clk_in); #1;
    bus.valid_in = 1'b0;
    n_checks++;
    if ({bus.valid_out, bus.res_out} !== {1'b1, 8'h30}) begin
      n_fail++; $display("FAIL stall_add_res: got v%b %h want v1 30", bus.valid_out, bus.res_out);
    end
    @(posedge clk_in); #1;
    n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL stall_extra_valid: got %b want 0", bus.valid_out); end
  endtask

  task automatic test_reset_mid_mul;
    int vld_cnt;
    bus.unit_sel_in = 3'b110; bus.op_sel_in = 1'b1; bus.acc_in = 8'hFF; bus.src_in = 8'hFF;
    bus.valid_in = 1'b1;
    @(posedge clk_in); #1;
    bus.valid_in = 1'b0;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    #1;
    n_checks++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", bus.ready_out); end
    n_checks++;
    if ({bus.valid_out, bus.res_out, bus.zero_out, bus.neg_out, bus.carry_out, bus.ovf_out} !== 13'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: got v%b %h flags %b want all 0", bus.valid_out, bus.res_out,
                         {bus.zero_out, bus.neg_out, bus.carry_out, bus.ovf_out});
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    vld_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_in); #1;
      if (bus.valid_out) vld_cnt++;
    end
    n_checks++; if (vld_cnt != 0) begin n_fail++; $display("FAIL rstmid_no_valid: got %0d pulses want 0", vld_cnt); end
    issue(3'b000, 1'b0, 8'h12, 8'h34);
    n_checks++;
    if ({bus.valid_out, bus.res_out, bus.carry_out, bus.ovf_out} !== {1'b1, 8'h46, 2'b00}) begin
      n_fail++; $display("FAIL rstmid_add: got v%b %h c%b v%b want v1 46 c0 v0", bus.valid_out, bus.res_out,
                         bus.carry_out, bus.ovf_out);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_in          = 1'b1;
    bus.valid_in    = 1'b0;
    bus.unit_sel_in = 3'b000;
    bus.op_sel_in   = 1'b0;
    bus.acc_in      = 8'h00;
    bus.src_in      = 8'h00;
    repeat (2) @(posedge clk_in);
    #1;
    test_reset();
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    test_add_overflow();
    test_sub_zero();
    test_shifts();
    test_logic();
    test_multiply();
    test_stall();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
